// File: rtl/semi_proc_pkg.sv
// semi_proc_pkg -- shared constants for the semi_proc controller.
//   Opcode values of the 16-bit instruction word, ALU operation select
//   codes, FSM state encodings (also shown on the debug state port) and
//   the instruction classes the decoder reports to the FSM.
package semi_proc_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_LDI  = 4'h6;
   localparam logic [3:0] OP_BEQZ = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      ALU_NOP    = 3'd0,
      ALU_ADD    = 3'd1,
      ALU_SUB    = 3'd2,
      ALU_AND    = 3'd3,
      ALU_OR     = 3'd4,
      ALU_XOR    = 3'd5,
      ALU_PASS_A = 3'd6,
      ALU_PASS_B = 3'd7
   } alu_op_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   // What the FSM has to do with an instruction once it sits in IR.
   typedef enum logic [2:0] {
      CLS_NOP     = 3'd0,
      CLS_WRITE   = 3'd1,
      CLS_BEQZ    = 3'd2,
      CLS_JMP     = 3'd3,
      CLS_HALT    = 3'd4,
      CLS_ILLEGAL = 3'd5
   } cls_t;

endpackage

// File: rtl/semi_proc_decode.sv
// semi_proc_decode -- combinational decode of the instruction register.
//   word    : instruction register contents
//   alu_op  : ALU operation select (alu_op_t encoding)
//   imm_sel : 1 = ALU B operand is the immediate
//   imm     : immediate field word[7:0]
//   ra, rb  : register-file read addresses
//   rd      : register-file write address
//   cls     : instruction class (cls_t encoding) for the FSM
module semi_proc_decode
   import semi_proc_pkg::*;
(
   input  logic [15:0] word,
   output logic [2:0]  alu_op,
   output logic        imm_sel,
   output logic [7:0]  imm,
   output logic [2:0]  ra,
   output logic [2:0]  rb,
   output logic [2:0]  rd,
   output logic [2:0]  cls
);

   assign rd  = word[11:9];
   assign ra  = word[8:6];
   assign rb  = word[5:3];
   assign imm = word[7:0];

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
      alu_op  = ALU_NOP;
      imm_sel = 1'b0;
      cls     = CLS_ILLEGAL;
      case (word[15:12])
         OP_NOP:  cls = CLS_NOP;
         OP_ADD:  begin alu_op = ALU_ADD; cls = CLS_WRITE; end
         OP_SUB:  begin alu_op = ALU_SUB; cls = CLS_WRITE; end
         OP_AND:  begin alu_op = ALU_AND; cls = CLS_WRITE; end
         OP_OR:   begin alu_op = ALU_OR;  cls = CLS_WRITE; end
         OP_XOR:  begin alu_op = ALU_XOR; cls = CLS_WRITE; end
         OP_LDI:  begin alu_op = ALU_PASS_B; imm_sel = 1'b1; cls = CLS_WRITE; end
         // BEQZ tests ra through the ALU zero flag.
         OP_BEQZ: begin alu_op = ALU_PASS_A; cls = CLS_BEQZ; end
         OP_JMP:  cls = CLS_JMP;
         OP_HALT: cls = CLS_HALT;
         default: cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/semi_proc_ctrl.sv
// semi_proc_ctrl -- multi-cycle controller for a tiny 16-bit processor.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : run request, honoured only in IDLE and HALT
//   instr        : program-memory data for address pc (one-cycle latency)
//   alu_zero     : ALU result==0, combinational from alu_op and operands
//   pc           : program counter
//   alu_op, imm, imm_sel, rf_raddr_a, rf_raddr_b : datapath controls from IR
//   rf_we, rf_waddr : register-file write strobe / address (WB only)
//   busy, halted, illegal, state : status and debug
// Flow: FETCH -> DECODE -> EXEC [-> WB] -> FETCH. Operand controls come
// straight from IR, so they hold from EXEC through WB without extra state.
module semi_proc_ctrl
   import semi_proc_pkg::*;
#(
   parameter int PC_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [15:0]     instr,
   input  logic            alu_zero,
   output logic [PC_W-1:0] pc,
   output logic [2:0]      alu_op,
   output logic [2:0]      rf_raddr_a,
   output logic [2:0]      rf_raddr_b,
   output logic            rf_we,
   output logic [2:0]      rf_waddr,
   output logic [7:0]      imm,
   output logic            imm_sel,
   output logic            busy,
   output logic            halted,
   output logic            illegal,
   output logic [2:0]      state
);

   state_t          cur;
   logic [15:0]     ir;
   logic [2:0]      rd;
   logic [2:0]      cls;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] target;

   semi_proc_decode u_decode (
      .word    (ir),
      .alu_op  (alu_op),
      .imm_sel (imm_sel),
      .imm     (imm),
      .ra      (rf_raddr_a),
      .rb      (rf_raddr_b),
      .rd      (rd),
      .cls     (cls)
   );

   // Natural PC_W-bit wrap gives 63 -> 0 with no flag.
   assign pc_inc = pc + PC_W'(1);
   // Branch/jump targets are the low PC_W bits of the immediate.
   assign target = PC_W'(imm);
   assign state  = cur;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur      <= S_IDLE;
         pc       <= '0;
         ir       <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         busy     <= 1'b0;
         halted   <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments; this default makes rf_we a one-cycle pulse.
         rf_we <= 1'b0;
         case (cur)
            S_IDLE, S_HALT: begin
               if (start) begin
                  cur     <= S_FETCH;
                  pc      <= '0;
                  busy    <= 1'b1;
                  halted  <= 1'b0;
                  illegal <= 1'b0;
               end
            end
            S_FETCH: cur <= S_DECODE;
            S_DECODE: begin
               // HALT leaves IR untouched so the datapath controls stay frozen.
               if (instr[15:12] == OP_HALT) begin
                  cur    <= S_HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  ir  <= instr;
                  cur <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (cls)
                  CLS_WRITE: begin
                     cur      <= S_WB;
                     rf_we    <= 1'b1;
                     rf_waddr <= rd;
                  end
                  CLS_BEQZ: begin
                     cur <= S_FETCH;
                     pc  <= alu_zero ? target : pc_inc;
                  end
                  CLS_JMP: begin
                     cur <= S_FETCH;
                     pc  <= target;
                  end
                  default: begin
                     // NOP and illegal opcodes both just advance.
                     cur <= S_FETCH;
                     pc  <= pc_inc;
                     if (cls == CLS_ILLEGAL) illegal <= 1'b1;
                  end
               endcase
            end
            S_WB: begin
               cur <= S_FETCH;
               pc  <= pc_inc;
            end
            default: begin
               cur    <= S_IDLE;
               busy   <= 1'b0;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_semi_proc_ctrl.sv
// tb_semi_proc_ctrl -- self-checking bench for semi_proc_ctrl.
//   The bench supplies a 64-word program memory with one-cycle read latency,
//   an 8x8 register file and an ALU driven by the controller outputs.
//   An instruction-level model (program counter, register values, sticky
//   illegal flag) predicts the outcome of each instruction: next pc, cycles
//   from FETCH to FETCH, the register write address and data, and status.
module tb_semi_proc_ctrl;
   import semi_proc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, start, alu_zero;
   logic [15:0] instr;
   logic [5:0]  pc;
   logic [2:0]  alu_op, rf_raddr_a, rf_raddr_b, rf_waddr, state;
   logic        rf_we, imm_sel, busy, halted, illegal;
   logic [7:0]  imm;

   always #5 clk = ~clk;

   semi_proc_ctrl #(.PC_W(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .instr      (instr),
      .alu_zero   (alu_zero),
      .pc         (pc),
      .alu_op     (alu_op),
      .rf_raddr_a (rf_raddr_a),
      .rf_raddr_b (rf_raddr_b),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .imm        (imm),
      .imm_sel    (imm_sel),
      .busy       (busy),
      .halted     (halted),
      .illegal    (illegal),
      .state      (state)
   );

   // ---------------- environment: memory, register file, ALU --------------
   logic [15:0] mem [64];
   logic [7:0]  rf [8];
   logic [7:0]  seed_val [8];
   logic        seed_rf = 1'b0;
   logic [7:0]  op_a, op_b, alu_res;

   always @(posedge clk) instr <= mem[pc];

   always @(posedge clk) begin
      if (seed_rf) begin
         for (int i = 0; i < 8; i++) rf[i] <= seed_val[i];
      end else if (rf_we) begin
         rf[rf_waddr] <= alu_res;
      end
   end

   always_comb begin
      op_a = rf[rf_raddr_a];
      op_b = imm_sel ? imm : rf[rf_raddr_b];
      case (alu_op)
         ALU_ADD:    alu_res = op_a + op_b;
         ALU_SUB:    alu_res = op_a - op_b;
         ALU_AND:    alu_res = op_a & op_b;
         ALU_OR:     alu_res = op_a | op_b;
         ALU_XOR:    alu_res = op_a ^ op_b;
         ALU_PASS_A: alu_res = op_a;
         ALU_PASS_B: alu_res = op_b;
         default:    alu_res = 8'd0;
      endcase
   end
   assign alu_zero = (alu_res == 8'd0);

   // ---------------- checking ---------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // ---------------- instruction-level model -------------------------------
   int         m_pc;
   logic [7:0] m_rf [8];
   bit         m_illegal;

   function automatic logic [2:0] exp_alu(input logic [3:0] op);
      case (op)
         4'h1:    return ALU_ADD;
         4'h2:    return ALU_SUB;
         4'h3:    return ALU_AND;
         4'h4:    return ALU_OR;
         4'h5:    return ALU_XOR;
         4'h6:    return ALU_PASS_B;
         default: return ALU_NOP;
      endcase
   endfunction

   function automatic logic [15:0] rand_instr();
      logic [15:0] w;
      int k;
      w = 16'($urandom);
      k = $urandom_range(0, 19);
      if (k < 2)        w[15:12] = 4'h0;
      else if (k < 10)  w[15:12] = 4'($urandom_range(1, 5));
      else if (k < 13)  w[15:12] = 4'h6;
      else if (k < 15)  w[15:12] = 4'h7;
      else if (k == 15) w[15:12] = 4'h8;
      else if (k < 18)  w[15:12] = 4'($urandom_range(9, 14));
      else if (k == 18) w[15:12] = 4'hF;
      else begin w[15:12] = 4'h6; w[7:0] = 8'h00; end
      return w;
   endfunction

   // One instruction, starting at a negedge with the DUT in FETCH.
   task automatic step_check(output bit halts);
      logic [15:0] w;
      logic [3:0]  op;
      logic [2:0]  rd, ra, rb;
      logic [7:0]  im, val;
      int          nxt, lat, n, we_seen;
      bit          writes;
      w  = mem[m_pc];
      op = w[15:12]; rd = w[11:9]; ra = w[8:6]; rb = w[5:3]; im = w[7:0];
      writes = 1'b0; halts = 1'b0; val = 8'd0;
      nxt = (m_pc + 1) % 64;
      case (op)
         4'h1: begin val = m_rf[ra] + m_rf[rb]; writes = 1'b1; end
         4'h2: begin val = m_rf[ra] - m_rf[rb]; writes = 1'b1; end
         4'h3: begin val = m_rf[ra] & m_rf[rb]; writes = 1'b1; end
         4'h4: begin val = m_rf[ra] | m_rf[rb]; writes = 1'b1; end
         4'h5: begin val = m_rf[ra] ^ m_rf[rb]; writes = 1'b1; end
         4'h6: begin val = im; writes = 1'b1; end
         4'h7: if (m_rf[ra] == 8'd0) nxt = int'(im[5:0]);
         4'h8: nxt = int'(im[5:0]);
         4'h0: ;
         4'hF: halts = 1'b1;
         default: m_illegal = 1'b1;
      endcase
      lat = writes ? 4 : 3;

      check("fetch_state", state, S_FETCH);
      check("fetch_pc", pc, m_pc);
      check("fetch_busy", busy, 1);

      n = 0; we_seen = 0;
      do begin
         @(negedge clk);
         n++;
         if (rf_we) begin
            we_seen++;
            check("we_state", state, S_WB);
            check("we_cycle", n, 3);
            check("waddr", rf_waddr, rd);
            check("wdata", alu_res, val);
            check("wb_alu_op", alu_op, exp_alu(op));
            check("wb_imm_sel", imm_sel, op == 4'h6);
            if (op == 4'h6) check("wb_imm", imm, im);
         end
         // start must be ignored while busy
         if (state == S_FETCH || state == S_HALT || n >= 8) start = 1'b0;
         else start = 1'($urandom_range(0, 1));
      end while (!(state == S_FETCH || state == S_HALT) && n < 8);

      if (halts) begin
         check("halt_state", state, S_HALT);
         check("halted", halted, 1);
         check("halt_busy", busy, 0);
         check("halt_pc", pc, m_pc);
      end else begin
         check("latency", n, lat);
         check("we_count", we_seen, writes);
         check("not_halted", halted, 0);
      end
      check("illegal", illegal, m_illegal);
      if (writes) m_rf[rd] = val;
      if (!halts) m_pc = nxt;
   endtask

   task automatic run_steps(input int max, output bit done);
      done = 1'b0;
      for (int i = 0; i < max && !done; i++) step_check(done);
   endtask

   task automatic launch();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_pc = 0;
      m_illegal = 1'b0;
      check("launch_halted", halted, 0);
      check("launch_illegal", illegal, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("rst_state", state, S_IDLE);
      check("rst_pc", pc, 0);
      check("rst_we", rf_we, 0);
      check("rst_alu_op", alu_op, ALU_NOP);
      check("rst_imm", imm, 0);
      check("rst_imm_sel", imm_sel, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_illegal", illegal, 0);
      rst_n = 1'b1;
   endtask

   task automatic seed_regs();
      for (int i = 0; i < 8; i++) begin
         seed_val[i] = 8'($urandom);
         if (i == 2) seed_val[i] = 8'($urandom_range(1, 255));
         m_rf[i] = seed_val[i];
      end
      seed_rf = 1'b1;
      @(negedge clk);
      seed_rf = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
   endtask

   // ---------------- main sequence ----------------------------------------
   initial begin
      bit done;
      int wait_n;
      rst_n = 1'b0;
      start = 1'b0;
      clear_mem();
      @(negedge clk);
      do_reset();
      repeat (3) @(negedge clk);
      check("idle_hold", state, S_IDLE);
      check("idle_pc", pc, 0);

      // LDI r1,5 then HALT; pc must stay frozen in HALT
      seed_regs();
      mem[0] = 16'h6205; mem[1] = 16'hF000;
      launch();
      run_steps(4, done);
      check("ldi_prog_halted", done, 1);
      repeat (3) @(negedge clk);
      check("halt_hold_state", state, S_HALT);
      check("halt_hold_pc", pc, 1);

      // JMP 20
      clear_mem();
      mem[0] = 16'h8014; mem[20] = 16'hF000;
      launch();
      run_steps(4, done);
      check("jmp_prog_halted", done, 1);

      // BEQZ r2 not taken, r2<=0, JMP 0, BEQZ r2 taken to 10
      clear_mem();
      mem[0] = 16'h708A; mem[1] = 16'h6400; mem[2] = 16'h8000; mem[10] = 16'hF000;
      seed_regs();
      launch();
      run_steps(8, done);
      check("beqz_prog_halted", done, 1);

      // illegal opcode, jump to 63, NOP wraps pc to 0
      clear_mem();
      mem[0] = 16'hA123; mem[1] = 16'h803F; mem[63] = 16'h0000;
      launch();
      run_steps(4, done);
      do_reset();

      // illegal flag is cleared by start from HALT
      clear_mem();
      mem[0] = 16'hA000; mem[1] = 16'hF000;
      launch();
      run_steps(4, done);
      launch();
      run_steps(4, done);
      check("illegal_prog_halted", done, 1);

      // reset while in WB aborts the write
      clear_mem();
      mem[0] = 16'h6205;
      launch();
      wait_n = 0;
      while (state != S_WB && wait_n < 10) begin
         @(negedge clk);
         wait_n++;
      end
      check("reach_wb", state, S_WB);
      do_reset();

      // randomized programs
      for (int r = 0; r < 8; r++) begin
         for (int a = 0; a < 64; a++) mem[a] = rand_instr();
         seed_regs();
         launch();
         run_steps(30, done);
         if (!done) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
